gpr_wb_arbiter: RTL

//  Writer side of the GPR write port (RegWr/rw/busW). Merges single-cycle ALU results with

---
 rtl/gpr_wb_pkg.sv | 20 ++
 rtl/gpr_wb_fifo.sv | 46 ++++
 rtl/gpr_wb_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/gpr_wb_pkg.sv
// Shared types and constants for the GPR write-back arbiter and its result FIFO.
package gpr_wb_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Which source owns the GPR write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO
  } wb_src_e;

endpackage

// File: rtl/gpr_wb_fifo.sv
// In-order buffer for long-latency write-back results; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter.
module gpr_wb_fifo
  import gpr_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              wdata,
  input  logic                   pop,
  output wb_entry_t              rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // NOTE: the storage array is deliberately not reset; an entry is only read after it
  // has been written, so validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: merges ALU results with buffered long-latency results, bounds
// FIFO starvation, and keeps the per-register busy scoreboard used by decode for RAW stalls.
module gpr_wb_arbiter
  import gpr_wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_wr_en,
  input  logic [REG_AW-1:0]      alu_wr_rd,
  input  logic [DATA_W-1:0]      alu_wr_data,
  output logic                   alu_wr_ready,
  input  logic                   ll_valid,
  input  logic [REG_AW-1:0]      ll_rd,
  input  logic [DATA_W-1:0]      ll_data,
  output logic                   ll_ready,
  input  logic                   iss_ll,
  input  logic [REG_AW-1:0]      iss_rd,
  input  logic [REG_AW-1:0]      q_ra,
  input  logic [REG_AW-1:0]      q_rb,
  output logic                   busy_a,
  output logic                   busy_b,
  output logic                   RegWr,
  output logic [REG_AW-1:0]      rw,
  output logic [DATA_W-1:0]      busW,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int NREG = 1 << REG_AW;

  wb_entry_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              force_fifo;
  logic              wr_fire;
  wb_src_e           src;
  logic [REG_AW-1:0] wr_rd;
  logic [DATA_W-1:0] wr_data;
  logic [SW-1:0]     starve_cnt;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;

  assign push = ll_valid && !fifo_full;

  gpr_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ('{rd: ll_rd, data: ll_data}),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign force_fifo   = !fifo_empty && (starve_cnt == SW'(STARVE_LIMIT));
  assign alu_wr_ready = !force_fifo;
  assign ll_ready     = !fifo_full;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    src      = SRC_NONE;
    wr_rd    = ZERO_REG;
    wr_data  = '0;
    if (force_fifo)       src = SRC_FIFO;
    else if (alu_wr_en)   src = SRC_ALU;
    else if (!fifo_empty) src = SRC_FIFO;

    if (src == SRC_ALU) begin
      wr_rd   = alu_wr_rd;
      wr_data = alu_wr_data;
    end else if (src == SRC_FIFO) begin
      wr_rd   = head.rd;
      wr_data = head.data;
    end
  end

  assign pop     = (src == SRC_FIFO);
  assign wr_fire = (src != SRC_NONE) && (wr_rd != ZERO_REG);

  // A pop and a new issue to the same register can coincide; the set is applied last so it wins.
  always_comb begin
    busy_nxt = busy;
    if (pop && head.rd != ZERO_REG)     busy_nxt[head.rd] = 1'b0;
    if (iss_ll && iss_rd != ZERO_REG)   busy_nxt[iss_rd]  = 1'b1;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      busy       <= '0;
      RegWr      <= 1'b0;
      rw         <= ZERO_REG;
      busW       <= '0;
    end else begin
      if (pop || fifo_empty)  starve_cnt <= '0;
      else if (src == SRC_ALU) starve_cnt <= starve_cnt + 1'b1;
      busy  <= busy_nxt;
      RegWr <= wr_fire;
      if (wr_fire) begin
        rw   <= wr_rd;
        busW <= wr_data;
      end
    end
  end

  assign busy_a = busy[q_ra];
  assign busy_b = busy[q_rb];

  // Decode must stall on busy, so a second issue to a pending register is only legal
  // in the cycle that register's result leaves the FIFO.
  a_one_outstanding: assert property (@(posedge clk) disable iff (rst)
    (iss_ll && iss_rd != ZERO_REG && busy[iss_rd]) |-> (pop && head.rd == iss_rd));

endmodule
